// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the load/store sequencer: FSM state encodings,
// request size codes, RAM control encodings and the RAM address width.
package mem_access_ctrl_pkg;

   localparam int RAM_AW_C = 10;

   localparam logic ENABLE    = 1'b1;
   localparam logic DISABLE   = 1'b0;
   localparam logic RAM_WRITE = 1'b1;
   localparam logic RAM_READ  = 1'b0;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      MEMC_IDLE = 2'd0,
      MEMC_RD   = 2'd1,
      MEMC_WR   = 2'd2,
      MEMC_RESP = 2'd3
   } memc_state_e;

   // Size code 3 is reserved and behaves as a word, so bit 1 marks a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == MEM_SIZE_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit
// Purely combinational byte-lane logic (little-endian lanes).
//   size_i      request size code
//   addr_lo_i   byte address bits [1:0]
//   signed_i    load extension select (1 = sign, 0 = zero)
//   wdata_i     right-aligned store data
//   buf_i       word previously read from RAM
//   merged_o    store word: new lane(s) merged over buf_i; word stores pass wdata_i
//   rdata_o     load result: selected lane(s) right-aligned and extended
// Half accesses only look at addr_lo_i[1], so misaligned halves and words
// fall back to their naturally aligned container.
module mem_lane_unit
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] buf_i,
   output logic [31:0] merged_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      merged_o = wdata_i;
      rdata_o  = buf_i;
      byte_sel = buf_i[{addr_lo_i, 3'b000} +: 8];
      half_sel = buf_i[{addr_lo_i[1], 4'b0000} +: 16];
      case (size_i)
         MEM_SIZE_BYTE: begin
            merged_o = buf_i;
            merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         end
         MEM_SIZE_HALF: begin
            merged_o = buf_i;
            merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
         end
         default: begin
            merged_o = wdata_i;
            rdata_o  = buf_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Load/store sequencer between the CPU MEM stage and a word-addressed 32-bit
// RAM. Sub-word stores are done as read-modify-write; loads are lane-extracted
// and extended. One single-cycle response per accepted request.
// Ports:
//   clk, reset                 system clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_wr/size/signed/addr/wdata  request fields (byte address)
//   resp_valid/rdata/err       one-cycle response
//   ram_en/wr/addr/wdata       RAM controls, decoded from registered state only
//   ram_rdata                  RAM read data, combinational
// Build option: MEM_ACCESS_ALIGN_CHECK_EN enables the misalignment check
// (error response, no RAM access). Without it resp_err is tied low and
// accesses are forced to natural alignment.
//
// state     | meaning
// MEMC_IDLE | ready for a request
// MEMC_RD   | RAM read, word captured into buffer
// MEMC_WR   | RAM write of merged (or full) word
// MEMC_RESP | one-cycle response
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int RAM_AW  = RAM_AW_C,
   parameter int BYTE_AW = RAM_AW + 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_wr,
   input  logic [1:0]         req_size,
   input  logic               req_signed,
   input  logic [BYTE_AW-1:0] req_addr,
   input  logic [31:0]        req_wdata,
   output logic               resp_valid,
   output logic [31:0]        resp_rdata,
   output logic               resp_err,
   output logic               ram_en,
   output logic               ram_wr,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic [31:0]        ram_wdata,
   input  logic [31:0]        ram_rdata
);

   memc_state_e        state_q, state_d;
   logic               wr_q;
   logic [1:0]         size_q;
   logic               signed_q;
   logic [BYTE_AW-1:0] addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        buf_q;
   logic               err_q;

   logic               accept;
   logic               req_mis;
   logic [31:0]        merged;
   logic [31:0]        load_data;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign req_mis  = is_misaligned(req_size, req_addr[1:0]);
   assign resp_err = resp_valid & err_q;
`else
   assign req_mis  = 1'b0;
   assign resp_err = 1'b0;
`endif

   assign accept = (state_q == MEMC_IDLE) && req_valid;

   mem_lane_unit u_lane (
      .size_i    (size_q),
      .addr_lo_i (addr_q[1:0]),
      .signed_i  (signed_q),
      .wdata_i   (wdata_q),
      .buf_i     (buf_q),
      .merged_o  (merged),
      .rdata_o   (load_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= MEMC_IDLE;
         wr_q     <= 1'b0;
         size_q   <= MEM_SIZE_BYTE;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         buf_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wr_q     <= req_wr;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_mis;
         end
         if (state_q == MEMC_RD) buf_q <= ram_rdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      ram_en     = DISABLE;
      ram_wr     = RAM_READ;
      ram_addr   = '0;
      ram_wdata  = '0;
      case (state_q)
         MEMC_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_mis)                   state_d = MEMC_RESP;
               else if (req_wr && req_size[1]) state_d = MEMC_WR;
               else                           state_d = MEMC_RD;
            end
         end
         MEMC_RD: begin
            ram_en   = ENABLE;
            ram_addr = addr_q[BYTE_AW-1:2];
            state_d  = wr_q ? MEMC_WR : MEMC_RESP;
         end
         MEMC_WR: begin
            ram_en    = ENABLE;
            ram_wr    = RAM_WRITE;
            ram_addr  = addr_q[BYTE_AW-1:2];
            ram_wdata = merged;
            state_d   = MEMC_RESP;
         end
         MEMC_RESP: begin
            resp_valid = 1'b1;
            if (!err_q && !wr_q) resp_rdata = load_data;
            state_d = MEMC_IDLE;
         end
         default: state_d = MEMC_IDLE;
      endcase
   end

endmodule
